// File: rtl/mlp_seq_pkg.sv
// mlp_seq_pkg
// Shared definitions for the MLP address sequencer: default widths, CSR word
// offsets, CTRL/STATUS bit positions and the sequencer state enum.
package mlp_seq_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // CSR word offsets
    localparam logic [2:0] CSR_CTRL   = 3'd0;
    localparam logic [2:0] CSR_STATUS = 3'd1;
    localparam logic [2:0] CSR_BASE   = 3'd2;
    localparam logic [2:0] CSR_COUNT  = 3'd3;
    localparam logic [2:0] CSR_STRIDE = 3'd4;
    localparam logic [2:0] CSR_MANUAL = 3'd5;
    localparam logic [2:0] CSR_POS    = 3'd6;
    localparam logic [2:0] CSR_RSVD   = 3'd7;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_ABORT  = 3;

    // STATUS bit positions
    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage

// File: rtl/mlp_addr_sequencer_if.sv
// mlp_addr_sequencer_if
// Bundles the Avalon-MM CSR slave signals and the address stream of the
// sequencer.
//   slave  : the sequencer (takes CSR requests, drives readdata/stream/irq)
//   master : the HPS + memory side (drives CSR requests and out_ready)
interface mlp_addr_sequencer_if #(
    parameter int ADDR_W = mlp_seq_pkg::ADDR_W_DEF
);
    logic [2:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              irq;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_addr, out_valid, out_last, irq
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_addr, out_valid, out_last, irq
    );
endinterface

// File: rtl/mlp_seq_csr.sv
// mlp_seq_csr
// CSR bank of the MLP address sequencer: register storage, write decode,
// sticky DONE with write-1-to-clear, and the combinational readdata mux.
// Ports:
//   clk, reset_n                : clock, synchronous active-low reset
//   address/chipselect/write_n/
//   writedata/readdata          : Avalon-MM CSR slave
//   busy, pos                   : live sequencer status for readback
//   done_set                    : sequencer request to set DONE
//   start_auto, abort           : single-cycle command pulses
//   mode, irq_en, done          : stored control/status bits
//   base, count, stride, manual : burst configuration
// MLP_ADDR_SEQ_IRQ_EN: when defined, CTRL.IRQ_EN is stored; otherwise it
// reads 0 and irq_en is tied low.
module mlp_seq_csr
    import mlp_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              busy,
    input  logic [CNT_W-1:0]  pos,
    input  logic              done_set,
    output logic              start_auto,
    output logic              abort,
    output logic              mode,
    output logic              irq_en,
    output logic              done,
    output logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] manual,
    output logic [CNT_W-1:0]  count
);
    logic              wr;
    logic              mode_q, mode_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] manual_q, manual_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              unused_wdata;

    assign wr = chipselect && !write_n;

    // START only means "launch" when the same CTRL write selects auto mode;
    // the FSM additionally ignores it while a burst is running.
    assign start_auto = wr && (address == CSR_CTRL) && writedata[CTRL_START]
                        && !writedata[CTRL_MODE];
    assign abort      = wr && (address == CSR_CTRL) && writedata[CTRL_ABORT];

    // Burst configuration is frozen while BUSY; a DONE set from the sequencer
    // beats a simultaneous write-1-to-clear.
    always_comb begin
        mode_d   = mode_q;
        done_d   = done_q;
        base_d   = base_q;
        stride_d = stride_q;
        manual_d = manual_q;
        count_d  = count_q;
        if (wr) begin
            case (address)
                CSR_CTRL:   if (!busy) mode_d = writedata[CTRL_MODE];
                CSR_STATUS: if (writedata[STATUS_DONE]) done_d = 1'b0;
                CSR_BASE:   if (!busy) base_d = writedata[ADDR_W-1:0];
                CSR_COUNT:  if (!busy) count_d = writedata[CNT_W-1:0];
                CSR_STRIDE: if (!busy) stride_d = writedata[ADDR_W-1:0];
                CSR_MANUAL: manual_d = writedata[ADDR_W-1:0];
                default:    ;
            endcase
        end
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            base_q   <= '0;
            stride_q <= '0;
            manual_q <= '0;
            count_q  <= '0;
        end else begin
            mode_q   <= mode_d;
            done_q   <= done_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            manual_q <= manual_d;
            count_q  <= count_d;
        end
    end

`ifdef MLP_ADDR_SEQ_IRQ_EN
    logic irq_en_q, irq_en_d;

    // IRQ_EN is not part of the frozen burst configuration.
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr && (address == CSR_CTRL)) begin
            irq_en_d = writedata[CTRL_IRQ_EN];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
        end
    end

    assign irq_en = irq_en_q;
`else
    assign irq_en = 1'b0;
`endif

    // Zero-wait-state readback; pulse bits and unused bits read 0.
    always_comb begin
        readdata = '0;
        case (address)
            CSR_CTRL: begin
                readdata[CTRL_MODE]   = mode_q;
                readdata[CTRL_IRQ_EN] = irq_en;
            end
            CSR_STATUS: begin
                readdata[STATUS_BUSY] = busy;
                readdata[STATUS_DONE] = done_q;
            end
            CSR_BASE:   readdata[ADDR_W-1:0] = base_q;
            CSR_COUNT:  readdata[CNT_W-1:0]  = count_q;
            CSR_STRIDE: readdata[ADDR_W-1:0] = stride_q;
            CSR_MANUAL: readdata[ADDR_W-1:0] = manual_q;
            CSR_POS:    readdata[CNT_W-1:0]  = pos;
            default:    readdata = '0;
        endcase
    end

    assign unused_wdata = ^writedata[31:ADDR_W] ^ ^writedata[31:CNT_W];

    assign mode   = mode_q;
    assign done   = done_q;
    assign base   = base_q;
    assign stride = stride_q;
    assign manual = manual_q;
    assign count  = count_q;

endmodule

// File: rtl/mlp_addr_sequencer.sv
// mlp_addr_sequencer
// Avalon-MM controlled address sequencer for the MLP weight/activation
// memories. Emits BASE, BASE+STRIDE, ... (COUNT beats, wrapping modulo
// 2^ADDR_W) on a valid/ready stream, or presents the MANUAL register when
// manual mode is selected.
// Ports:
//   clk     : single clock
//   reset_n : synchronous active-low reset
//   bus     : mlp_addr_sequencer_if.slave (CSR slave, address stream, irq)
// MLP_ADDR_SEQ_IRQ_EN: when defined, irq is a registered DONE && IRQ_EN;
// otherwise irq is tied to 0.
module mlp_addr_sequencer
    import mlp_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mlp_addr_sequencer_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  pos_q, pos_d;
    logic              done_set;
    logic              handshake;
    logic              is_last;

    logic              start_auto, abort, mode, irq_en, done;
    logic [ADDR_W-1:0] base, stride, manual;
    logic [CNT_W-1:0]  count;

    mlp_seq_csr #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_csr (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (bus.address),
        .chipselect (bus.chipselect),
        .write_n    (bus.write_n),
        .writedata  (bus.writedata),
        .readdata   (bus.readdata),
        .busy       (state_q == RUN),
        .pos        (pos_q),
        .done_set   (done_set),
        .start_auto (start_auto),
        .abort      (abort),
        .mode       (mode),
        .irq_en     (irq_en),
        .done       (done),
        .base       (base),
        .stride     (stride),
        .manual     (manual),
        .count      (count)
    );

    assign handshake = (state_q == RUN) && bus.out_ready;
    assign is_last   = (pos_q == count - CNT_ONE);

    // addr_q is both the current burst address and the "last value driven"
    // that auto mode holds in IDLE; while idle in manual mode it tracks
    // MANUAL so a later switch to auto keeps presenting that address.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pos_d    = pos_q;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode) begin
                    addr_d = manual;
                end
                if (start_auto) begin
                    if (count == '0) begin
                        done_set = 1'b1;
                    end else begin
                        state_d = RUN;
                        addr_d  = base;
                        pos_d   = '0;
                    end
                end
            end
            RUN: begin
                // A handshake in the ABORT cycle still counts.
                if (handshake) begin
                    pos_d = pos_q + CNT_ONE;
                    if (is_last) begin
                        state_d  = IDLE;
                        done_set = 1'b1;
                    end else begin
                        addr_d = addr_q + stride;
                    end
                end
                if (abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pos_q   <= pos_d;
        end
    end

    // MANUAL is presented directly so a MANUAL write shows up one cycle later.
    assign bus.out_addr  = ((state_q == IDLE) && mode) ? manual : addr_q;
    assign bus.out_valid = (state_q == RUN);
    assign bus.out_last  = (state_q == RUN) && is_last;

`ifdef MLP_ADDR_SEQ_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= done && irq_en;
        end
    end

    assign bus.irq = irq_q;
`else
    logic unused_irq;
    assign unused_irq = done ^ irq_en;
    assign bus.irq    = 1'b0;
`endif

endmodule

// File: tb/tb_mlp_addr_sequencer.sv
// tb_mlp_addr_sequencer
// Self-checking bench for mlp_addr_sequencer. Expected addresses come from
// base + i*stride mod 2^16; expected POS/DONE/BUSY from the beat count.
// Honours MLP_ADDR_SEQ_IRQ_EN in the same way as the design.
module tb_mlp_addr_sequencer;
    import mlp_seq_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    mlp_addr_sequencer_if #(.ADDR_W(16)) bus ();

    mlp_addr_sequencer #(
        .ADDR_W (16),
        .CNT_W  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, time=%0t required=<500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        #1;
        d = bus.readdata;
    endtask

    // One burst against the arithmetic reference; ready comes either from a
    // per-cycle pattern or from $urandom (forced high after 32 cycles).
    task automatic run_burst(input logic [15:0] base, input logic [15:0] stride,
                             input int count, input logic [31:0] ready_pat,
                             input bit rnd_ready, input string tag);
        logic [31:0] rd;
        logic [15:0] exp_addr;
        logic        exp_last;
        logic        rdy;
        int          idx;
        int          cyc;
        idx = 0;
        cyc = 0;
        bus.out_ready = 1'b0;
        csr_write(CSR_STATUS, 32'h2);
        csr_write(CSR_BASE, {16'h0, base});
        csr_write(CSR_COUNT, 32'(count));
        csr_write(CSR_STRIDE, {16'h0, stride});
        csr_write(CSR_CTRL, 32'h1);
        while (idx < count && cyc < 100) begin
            exp_addr = 16'(int'(base) + idx * int'(stride));
            exp_last = (idx == count - 1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== exp_addr || bus.out_last !== exp_last) begin
                failures++;
                $display("[TB] FAIL %s beat%0d: valid=%b addr=%h last=%b required valid=1 addr=%h last=%b",
                         tag, idx, bus.out_valid, bus.out_addr, bus.out_last, exp_addr, exp_last);
            end
            if (rnd_ready) rdy = (($urandom % 2) == 1) || (cyc >= 32);
            else           rdy = (cyc < 32) ? ready_pat[cyc] : 1'b1;
            bus.out_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            cyc++;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (idx != count) begin
            failures++;
            $display("[TB] FAIL %s timeout: beats=%0d required=%0d", tag, idx, count);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s valid_after_end: got %b required 0", tag, bus.out_valid);
        end
        csr_read(CSR_STATUS, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("[TB] FAIL %s status_end: got %h required 00000002", tag, rd);
        end
        csr_read(CSR_POS, rd);
        checks++;
        if (rd !== 32'(count)) begin
            failures++;
            $display("[TB] FAIL %s pos_end: got %0d required %0d", tag, rd, count);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_addr !== 16'h0 || bus.out_last !== 1'b0 || bus.irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: valid=%b addr=%h last=%b irq=%b required all 0",
                     bus.out_valid, bus.out_addr, bus.out_last, bus.irq);
        end
        for (int a = 0; a < 8; a++) begin
            csr_read(3'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_csr%0d: got %h required 00000000", a, rd);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_burst();
        run_burst(16'h0100, 16'h0004, 3, 32'hFFFF_FFFF, 1'b0, "basic");
    endtask

    task automatic test_ready_stall();
        run_burst(16'h0100, 16'h0004, 3, 32'h0000_0019, 1'b0, "stall");
    endtask

    task automatic test_wrap();
        run_burst(16'hFFFE, 16'h0003, 3, 32'hFFFF_FFFF, 1'b0, "wrap");
    endtask

    task automatic test_random_bursts();
        for (int r = 0; r < 4; r++) begin
            run_burst(16'($urandom), 16'($urandom), int'($urandom_range(1, 6)), 32'h0, 1'b1, "random");
        end
    endtask

    task automatic test_count_zero();
        logic [31:0] rd;
        logic [31:0] exp_ctrl;
        csr_write(CSR_STATUS, 32'h2);
        csr_write(CSR_COUNT, 32'h0);
        csr_write(CSR_CTRL, 32'h5);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cnt0_valid: got %b required 0", bus.out_valid);
        end
        csr_read(CSR_STATUS, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("[TB] FAIL cnt0_status: got %h required 00000002", rd);
        end
`ifdef MLP_ADDR_SEQ_IRQ_EN
        exp_ctrl = 32'h4;
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cnt0_irq_early: got %b required 0", bus.irq);
        end
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cnt0_irq_rise: irq=%b valid=%b required irq=1 valid=0", bus.irq, bus.out_valid);
        end
        csr_write(CSR_STATUS, 32'h2);
        csr_read(CSR_STATUS, rd);
        checks++;
        if (rd !== 32'h0 || bus.irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL cnt0_w1c: status=%h irq=%b required status=0 irq=1", rd, bus.irq);
        end
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cnt0_irq_clear: got %b required 0", bus.irq);
        end
`else
        exp_ctrl = 32'h0;
        @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL cnt0_irq_tied: irq=%b valid=%b required 0 0", bus.irq, bus.out_valid);
        end
`endif
        csr_read(CSR_CTRL, rd);
        checks++;
        if (rd !== exp_ctrl) begin
            failures++;
            $display("[TB] FAIL cnt0_ctrl_read: got %h required %h", rd, exp_ctrl);
        end
        csr_write(CSR_CTRL, 32'h0);
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic [15:0] exp_addr;
        bus.out_ready = 1'b0;
        csr_write(CSR_STATUS, 32'h2);
        csr_write(CSR_BASE, 32'h0200);
        csr_write(CSR_COUNT, 32'd10);
        csr_write(CSR_STRIDE, 32'h0010);
        csr_write(CSR_CTRL, 32'h1);
        csr_write(CSR_BASE, 32'hDEAD);
        csr_read(CSR_STATUS, rd);
        checks++;
        if (rd !== 32'h1) begin
            failures++;
            $display("[TB] FAIL abort_busy: got %h required 00000001", rd);
        end
        for (int k = 0; k < 4; k++) begin
            exp_addr = 16'(32'h0200 + k * 32'h10);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_addr !== exp_addr) begin
                failures++;
                $display("[TB] FAIL abort_beat%0d: valid=%b addr=%h required valid=1 addr=%h",
                         k, bus.out_valid, bus.out_addr, exp_addr);
            end
            bus.out_ready = 1'b1;
            if (k < 3) @(negedge clk);
            else       csr_write(CSR_CTRL, 32'h8);
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_valid: got %b required 0", bus.out_valid);
        end
        csr_read(CSR_POS, rd);
        checks++;
        if (rd !== 32'd4) begin
            failures++;
            $display("[TB] FAIL abort_pos: got %0d required 4", rd);
        end
        csr_read(CSR_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL abort_status: got %h required 00000000", rd);
        end
        csr_read(CSR_BASE, rd);
        checks++;
        if (rd !== 32'h0200) begin
            failures++;
            $display("[TB] FAIL abort_base_locked: got %h required 00000200", rd);
        end
    endtask

    task automatic test_manual();
        logic [31:0] rd;
        csr_write(CSR_CTRL, 32'h2);
        csr_write(CSR_MANUAL, 32'h1234);
        checks++;
        if (bus.out_addr !== 16'h1234 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL manual_addr: addr=%h valid=%b required 1234 0", bus.out_addr, bus.out_valid);
        end
        csr_write(CSR_CTRL, 32'h3);
        @(negedge clk);
        csr_read(CSR_STATUS, rd);
        checks++;
        if (rd !== 32'h0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL manual_start_ignored: status=%h valid=%b required 0 0", rd, bus.out_valid);
        end
        csr_read(CSR_CTRL, rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("[TB] FAIL manual_ctrl_read: got %h required 00000002", rd);
        end
        csr_write(CSR_CTRL, 32'h0);
        checks++;
        if (bus.out_addr !== 16'h1234) begin
            failures++;
            $display("[TB] FAIL auto_hold_addr: got %h required 1234", bus.out_addr);
        end
    endtask

    task automatic test_reset_in_run();
        logic [31:0] rd;
        bus.out_ready = 1'b0;
        csr_write(CSR_BASE, 32'h0300);
        csr_write(CSR_COUNT, 32'd5);
        csr_write(CSR_STRIDE, 32'h1);
        csr_write(CSR_CTRL, 32'h1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_addr !== 16'h0300) begin
            failures++;
            $display("[TB] FAIL rrun_started: valid=%b addr=%h required 1 0300", bus.out_valid, bus.out_addr);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_addr !== 16'h0 || bus.out_last !== 1'b0 || bus.irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rrun_outputs: valid=%b addr=%h last=%b irq=%b required all 0",
                     bus.out_valid, bus.out_addr, bus.out_last, bus.irq);
        end
        csr_read(CSR_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rrun_status: got %h required 00000000", rd);
        end
        csr_read(CSR_BASE, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rrun_base: got %h required 00000000", rd);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_basic_burst();
        test_ready_stall();
        test_wrap();
        test_count_zero();
        test_abort();
        test_manual();
        test_random_bursts();
        test_reset_in_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mlp_addr_sequencer.md
# mlp_addr_sequencer

Avalon-MM-controlled address sequencer that drives the 16-bit address bus feeding the MLP weight/activation memories. It replaces the plain software-written address port, which remains available as a manual mode. The HPS programs base, count and stride, then starts a burst. The block emits one address per accepted beat on a valid/ready stream and flags completion by a sticky status bit and an optional interrupt.

## Interface
- ADDR_W, 16, width of generated address and of BASE/STRIDE/MANUAL registers
- CNT_W, 16, width of COUNT and position index
- clk  in  1  single clock
- reset_n  in  1  synchronous, active-low reset
- address  in  3  CSR word offset
- chipselect  in  1  CSR select
- write_n  in  1  active-low CSR write strobe
- writedata  in  32  CSR write data
- readdata  out  32  CSR read data; combinational, zero wait states; unused bits 0
- out_addr  out  ADDR_W  current address
- out_valid  out  1  out_addr is a sequenced beat
- out_ready  in  1  consumer accepts the beat
- out_last  out  1  final beat of the burst; qualified by out_valid
- irq  out  1  level interrupt

Clock and reset are decided: one clock, clk; reset_n is synchronous and active-low.

## Operation
- CSR map:
  - 0 CTRL: b0 START (write-1 pulse), b1 MODE (0 = auto, 1 = manual), b2 IRQ_EN, b3 ABORT (write-1 pulse). Pulse bits read 0.
  - 1 STATUS: b0 BUSY (RO), b1 DONE (sticky; write 1 to clear).
  - 2 BASE
  - 3 COUNT
  - 4 STRIDE
  - 5 MANUAL
  - 6 POS: beats accepted so far (RO).
  - 7 reserved: reads 0, writes ignored.
- A write is `chipselect && !write_n`.
- Writes to BASE, COUNT, STRIDE and MODE while BUSY are ignored.
- FSM states: IDLE, RUN.
  - IDLE → RUN: START with MODE=0 and COUNT≠0. On the transition: cur ← BASE, POS ← 0.
  - START with COUNT=0: DONE is set at once, no beat is emitted, the FSM stays in IDLE.
  - START with MODE=1 is ignored.
  - In RUN: out_valid=1 and out_addr=cur.
  - On a handshake (out_valid && out_ready):
    - POS increments.
    - If POS was COUNT-1: go to IDLE and set DONE.
    - Otherwise cur ← cur + STRIDE, modulo 2^ADDR_W (wraps silently).
  - out_last = (POS == COUNT-1) while in RUN.
  - ABORT in RUN: go to IDLE, DONE not set, POS keeps its value.
  - START while in RUN is ignored.
- out_valid must stay high with out_addr stable until the handshake; the block never withdraws a beat except on ABORT or reset.
- Manual mode (MODE=1, IDLE): out_addr = MANUAL register; out_valid = 0.
- Auto mode while IDLE: out_addr holds the last value driven.
- BUSY = (state == RUN).

## Timing
- Reset values:
  - All CSRs 0.
  - State IDLE.
  - out_addr 0, out_valid 0, out_last 0, irq 0.
- First beat: out_valid rises the cycle after the START write cycle.
- Throughput: one beat per cycle while out_ready is held high. A burst of N beats finishes N cycles after out_valid rises.
- DONE and BUSY=0 are visible on the cycle after the final handshake. out_valid is 0 on that same cycle.
- ABORT takes effect on the next cycle. A handshake on the ABORT write cycle is still counted.
- DONE set and a W1C write to DONE in the same cycle: set wins.
- MANUAL write in manual mode: out_addr follows on the next cycle.
- A reset asserted during RUN returns to IDLE with all outputs at reset values on the next edge.

## Configuration
- MLP_ADDR_SEQ_IRQ_EN defined:
  - irq is registered: irq = DONE && IRQ_EN.
  - irq rises the cycle after DONE sets and clears the cycle after DONE is cleared.
- MLP_ADDR_SEQ_IRQ_EN undefined:
  - irq is tied to 0.
  - CTRL.b2 is not stored and reads 0.
  - All other behaviour is identical.

## Structure
- Shared package mlp_seq_pkg holds:
  - CSR offset constants
  - CTRL/STATUS bit-position constants
  - the state enum (IDLE, RUN)
  - default ADDR_W and CNT_W
- Sub-module mlp_seq_csr holds:
  - register storage, write decode, W1C logic and the readdata mux
  - outputs: start/abort pulses and configuration values to the top-level FSM/counter logic.

## Test plan
- BASE=0x0100, STRIDE=4, COUNT=3, START, out_ready=1 → out_addr sequence 0x0100, 0x0104, 0x0108 on consecutive cycles. out_last is high on 0x0108 only. The next cycle reads DONE=1, BUSY=0, POS=3.
- Same burst with out_ready toggling 1,0,0,1,1 → each address is held stable while out_ready is low. Exactly 3 handshakes occur and DONE sets after the third.
- BASE=0xFFFE, STRIDE=3, COUNT=3 → addresses 0xFFFE, 0x0001, 0x0004 (wrap).
- COUNT=0 then START → out_valid never rises and DONE=1 on the next cycle. With the macro defined and IRQ_EN=1, irq rises one cycle later; writing STATUS=0x2 clears DONE, and irq clears one cycle after that.
- COUNT=10, START, ABORT after 4 handshakes → out_valid drops the next cycle. POS reads 4, DONE=0, BUSY=0. A BASE write issued while BUSY earlier in the test is not retained.
- MODE=1, MANUAL=0x1234 → out_addr reads 0x1234 the next cycle with out_valid=0. A START issued in this mode is ignored (BUSY stays 0).
